// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
//
// Asynchronous serial transmitter. A parallel word is accepted through a
// valid/busy handshake and sent as: start bit (0), DATA_WIDTH data bits
// LSB first, an optional parity bit, and one stop bit (1). Every serial bit
// is held for PRESCALE clock cycles.
//
// Parameters
//   DATA_WIDTH  data bits per frame (>= 1)
//   PRESCALE    clock cycles per serial bit (>= 2)
//
// Ports
//   CLK         clock, all state changes on the rising edge
//   RST         asynchronous active-high reset
//   P_DATA      parallel word, captured on acceptance
//   DATA_VALID  send request, honoured only while idle
//   PAR_EN      1 = append a parity bit, captured on acceptance
//   PAR_TYP     0 = even parity, 1 = odd parity, captured on acceptance
//   TX_OUT      registered serial line, idles high
//   BUSY        registered, high while a frame is in progress
// -----------------------------------------------------------------------------
module uart_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE   = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  BUSY
);

  localparam int CNT_W = $clog2(PRESCALE);
  localparam int IDX_W = $clog2(DATA_WIDTH + 1);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e                  state_q,   state_d;
  logic [CNT_W-1:0]        cnt_q,     cnt_d;
  logic [IDX_W-1:0]        idx_q,     idx_d;
  logic [DATA_WIDTH-1:0]   shadow_q,  shadow_d;
  logic                    par_en_q,  par_en_d;
  logic                    par_typ_q, par_typ_d;
  logic                    tx_q,      tx_d;
  logic                    busy_q,    busy_d;

  logic                    bit_done;
  logic                    data_bit;

  // Last cycle of the current serial bit.
  assign bit_done = (cnt_q == CNT_LAST);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shadow_d  = shadow_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;

    unique case (state_q)
      S_IDLE: begin
        if (DATA_VALID) begin
          shadow_d  = P_DATA;
          par_en_d  = PAR_EN;
          par_typ_d = PAR_TYP;
          cnt_d     = '0;
          state_d   = S_START;
        end
      end

      S_START: begin
        if (bit_done) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_DATA: begin
        if (bit_done) begin
          cnt_d = '0;
          if (idx_q == IDX_LAST) begin
            state_d = par_en_q ? S_PARITY : S_STOP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_PARITY: begin
        if (bit_done) begin
          cnt_d   = '0;
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_STOP: begin
        if (bit_done) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode. The outputs are registered, so they are computed from the
  // *next* state: the line already shows the start bit in the cycle right
  // after the acceptance edge, and BUSY drops on the edge that ends the stop
  // bit. No input reaches an output without passing through a flop.
  // ---------------------------------------------------------------------------
  always_comb begin
    data_bit = 1'b0;
    // Explicit mux rather than a variable part-select: the index register is
    // one bit wider than needed to address the shadow word.
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (idx_d == IDX_W'(i)) data_bit = shadow_d[i];
    end

    tx_d = 1'b1;
    unique case (state_d)
      S_IDLE:   tx_d = 1'b1;
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = data_bit;
      S_PARITY: tx_d = (^shadow_d) ^ par_typ_d;
      S_STOP:   tx_d = 1'b1;
      default:  tx_d = 1'b1;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      // NOTE: the shadow word is reset as well, even though it is always
      // reloaded before use, so that no stale data survives a reset.
      shadow_q  <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values that
      // existed before this edge, independent of statement order.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  assign TX_OUT = tx_q;
  assign BUSY   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx
//
// Directed bench for uart_tx. Two instances share clock and reset: the main
// one at DATA_WIDTH=8 / PRESCALE=8 and a small one at DATA_WIDTH=5 /
// PRESCALE=2. Outputs are sampled on the falling clock edge; sample k taken
// after an acceptance edge T0 belongs to clock cycle T0+1+k.
// -----------------------------------------------------------------------------
module tb_uart_tx;

  localparam int P   = 8;
  localparam int SP  = 2;
  localparam int NS  = 200;

  logic       clk;
  logic       rst;
  logic [7:0] p_data;
  logic       data_valid;
  logic       par_en;
  logic       par_typ;
  logic       tx_out;
  logic       busy;

  logic [4:0] s_data;
  logic       s_valid;
  logic       s_par_en;
  logic       s_par_typ;
  logic       s_tx;
  logic       s_busy;

  int n_cmp = 0;
  int n_err = 0;

  logic tx_s     [NS];
  logic busy_s   [NS];
  logic s_tx_s   [NS];
  logic s_busy_s [NS];

  uart_tx #(.DATA_WIDTH(8), .PRESCALE(P)) u_dut (
    .CLK        (clk),
    .RST        (rst),
    .P_DATA     (p_data),
    .DATA_VALID (data_valid),
    .PAR_EN     (par_en),
    .PAR_TYP    (par_typ),
    .TX_OUT     (tx_out),
    .BUSY       (busy)
  );

  uart_tx #(.DATA_WIDTH(5), .PRESCALE(SP)) u_small (
    .CLK        (clk),
    .RST        (rst),
    .P_DATA     (s_data),
    .DATA_VALID (s_valid),
    .PAR_EN     (s_par_en),
    .PAR_TYP    (s_par_typ),
    .TX_OUT     (s_tx),
    .BUSY       (s_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Serial bit i of an expected frame (bit 0 = start bit).
  function automatic logic bit_at(input logic [15:0] seq, input int i);
    logic [15:0] t;
    t = seq >> i;
    return t[0];
  endfunction

  // Record both instances' outputs on the next n falling edges.
  task automatic capture(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      tx_s[k]     = tx_out;
      busy_s[k]   = busy;
      s_tx_s[k]   = s_tx;
      s_busy_s[k] = s_busy;
    end
  endtask

  // Present a word, let the next rising edge accept it, then (unless held)
  // drop the request and scramble the inputs to prove they were latched.
  task automatic send(input logic [7:0] d, input logic pe, input logic pt,
                      input bit hold);
    @(negedge clk);
    p_data     = d;
    par_en     = pe;
    par_typ    = pt;
    data_valid = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) begin
      data_valid = 1'b0;
      p_data     = ~d;
      par_en     = ~pe;
      par_typ    = ~pt;
    end
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    data_valid = 1'b0;
    p_data     = 8'h00;
    par_en     = 1'b0;
    par_typ    = 1'b0;
    s_valid    = 1'b0;
    s_data     = 5'h00;
    s_par_en   = 1'b0;
    s_par_typ  = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({busy, tx_out} !== 2'b01) begin
      n_err++;
      $display("FAIL reset_main: got busy/tx=%b%b want 01", busy, tx_out);
    end
    n_cmp++;
    if ({s_busy, s_tx} !== 2'b01) begin
      n_err++;
      $display("FAIL reset_small: got busy/tx=%b%b want 01", s_busy, s_tx);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({busy, tx_out} !== 2'b01) begin
      n_err++;
      $display("FAIL post_reset_idle: got busy/tx=%b%b want 01", busy, tx_out);
    end
  endtask

  task automatic test_no_parity();
    // 0xA5 framed: 0,1,0,1,0,0,1,0,1,1 (bit 0 first).
    logic [15:0] exp;
    exp = 16'b0000_0011_0100_1010;
    send(8'hA5, 1'b0, 1'b0, 1'b0);
    capture(82);
    for (int k = 0; k < 80; k++) begin
      n_cmp++;
      if ({busy_s[k], tx_s[k]} !== {1'b1, bit_at(exp, k / P)}) begin
        n_err++;
        $display("FAIL a5_nopar cyc %0d: got busy/tx=%b%b want 1%b",
                 k, busy_s[k], tx_s[k], bit_at(exp, k / P));
      end
    end
    for (int k = 80; k < 82; k++) begin
      n_cmp++;
      if ({busy_s[k], tx_s[k]} !== 2'b01) begin
        n_err++;
        $display("FAIL a5_nopar_idle cyc %0d: got busy/tx=%b%b want 01",
                 k, busy_s[k], tx_s[k]);
      end
    end
  endtask

  task automatic test_parity();
    logic [7:0]  td   [4];
    logic        tp   [4];
    logic        tpar [4];
    logic [15:0] exp;
    td   = '{8'hA5, 8'hA5, 8'h00, 8'h01};
    tp   = '{1'b0,  1'b1,  1'b1,  1'b0};
    tpar = '{1'b0,  1'b1,  1'b1,  1'b1};
    for (int i = 0; i < 4; i++) begin
      exp = 16'({1'b1, tpar[i], td[i], 1'b0});
      send(td[i], 1'b1, tp[i], 1'b0);
      capture(89);
      for (int k = 0; k < 88; k++) begin
        n_cmp++;
        if ({busy_s[k], tx_s[k]} !== {1'b1, bit_at(exp, k / P)}) begin
          n_err++;
          $display("FAIL parity_%0d cyc %0d: got busy/tx=%b%b want 1%b",
                   i, k, busy_s[k], tx_s[k], bit_at(exp, k / P));
        end
      end
      n_cmp++;
      if ({busy_s[88], tx_s[88]} !== 2'b01) begin
        n_err++;
        $display("FAIL parity_%0d_end: got busy/tx=%b%b want 01",
                 i, busy_s[88], tx_s[88]);
      end
    end
  endtask

  task automatic test_busy_ignore();
    // 0x3C has four ones, even parity bit 0, frame 88 cycles.
    logic [15:0] exp;
    exp = 16'({1'b1, 1'b0, 8'h3C, 1'b0});
    send(8'h3C, 1'b1, 1'b0, 1'b0);
    fork
      capture(110);
      begin
        repeat (20) @(negedge clk);
        p_data     = 8'hFF;
        par_en     = 1'b0;
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
      end
    join
    for (int k = 0; k < 88; k++) begin
      n_cmp++;
      if ({busy_s[k], tx_s[k]} !== {1'b1, bit_at(exp, k / P)}) begin
        n_err++;
        $display("FAIL busy_ignore cyc %0d: got busy/tx=%b%b want 1%b",
                 k, busy_s[k], tx_s[k], bit_at(exp, k / P));
      end
    end
    for (int k = 88; k < 110; k++) begin
      n_cmp++;
      if ({busy_s[k], tx_s[k]} !== 2'b01) begin
        n_err++;
        $display("FAIL busy_ignore_no_second cyc %0d: got busy/tx=%b%b want 01",
                 k, busy_s[k], tx_s[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp1;
    logic [15:0] exp2;
    logic        want_tx;
    logic        want_busy;
    exp1 = 16'({1'b1, 8'h55, 1'b0});
    exp2 = 16'({1'b1, 8'hAA, 1'b0});
    send(8'h55, 1'b0, 1'b0, 1'b1);
    p_data = 8'hAA;
    fork
      capture(162);
      begin
        // The 81st rising edge after T0 is the second acceptance.
        repeat (81) @(posedge clk);
        #1;
        data_valid = 1'b0;
      end
    join
    for (int k = 0; k < 162; k++) begin
      if (k < 80) begin
        want_busy = 1'b1;
        want_tx   = bit_at(exp1, k / P);
      end else if (k >= 81 && k < 161) begin
        want_busy = 1'b1;
        want_tx   = bit_at(exp2, (k - 81) / P);
      end else begin
        want_busy = 1'b0;
        want_tx   = 1'b1;
      end
      n_cmp++;
      if ({busy_s[k], tx_s[k]} !== {want_busy, want_tx}) begin
        n_err++;
        $display("FAIL back_to_back cyc %0d: got busy/tx=%b%b want %b%b",
                 k, busy_s[k], tx_s[k], want_busy, want_tx);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [15:0] exp;
    // Sample 35 falls in serial bit 4 = data bit 3 of 0xF0, which is 0.
    send(8'hF0, 1'b0, 1'b0, 1'b0);
    capture(36);
    n_cmp++;
    if ({busy_s[35], tx_s[35]} !== 2'b10) begin
      n_err++;
      $display("FAIL pre_reset_bit3: got busy/tx=%b%b want 10",
               busy_s[35], tx_s[35]);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({busy, tx_out} !== 2'b01) begin
      n_err++;
      $display("FAIL async_reset: got busy/tx=%b%b want 01", busy, tx_out);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({busy, tx_out} !== 2'b01) begin
      n_err++;
      $display("FAIL reset_release_idle: got busy/tx=%b%b want 01", busy, tx_out);
    end
    exp = 16'({1'b1, 8'h81, 1'b0});
    send(8'h81, 1'b0, 1'b0, 1'b0);
    capture(81);
    for (int k = 0; k < 80; k++) begin
      n_cmp++;
      if ({busy_s[k], tx_s[k]} !== {1'b1, bit_at(exp, k / P)}) begin
        n_err++;
        $display("FAIL after_reset_81 cyc %0d: got busy/tx=%b%b want 1%b",
                 k, busy_s[k], tx_s[k], bit_at(exp, k / P));
      end
    end
    n_cmp++;
    if ({busy_s[80], tx_s[80]} !== 2'b01) begin
      n_err++;
      $display("FAIL after_reset_81_end: got busy/tx=%b%b want 01",
               busy_s[80], tx_s[80]);
    end
  endtask

  task automatic test_small_corner();
    // 0x1F, odd parity: 0,1,1,1,1,1,0,1 (bit 0 first), 2 cycles each.
    logic [15:0] exp;
    exp = 16'b0000_0000_1011_1110;
    @(negedge clk);
    s_data    = 5'h1F;
    s_par_en  = 1'b1;
    s_par_typ = 1'b1;
    s_valid   = 1'b1;
    @(posedge clk);
    #1;
    s_valid   = 1'b0;
    s_data    = 5'h00;
    s_par_typ = 1'b0;
    capture(18);
    for (int k = 0; k < 16; k++) begin
      n_cmp++;
      if ({s_busy_s[k], s_tx_s[k]} !== {1'b1, bit_at(exp, k / SP)}) begin
        n_err++;
        $display("FAIL small cyc %0d: got busy/tx=%b%b want 1%b",
                 k, s_busy_s[k], s_tx_s[k], bit_at(exp, k / SP));
      end
    end
    for (int k = 16; k < 18; k++) begin
      n_cmp++;
      if ({s_busy_s[k], s_tx_s[k]} !== 2'b01) begin
        n_err++;
        $display("FAIL small_idle cyc %0d: got busy/tx=%b%b want 01",
                 k, s_busy_s[k], s_tx_s[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_no_parity();
    test_parity();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid_frame();
    test_small_corner();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
